rtc_access_scheduler: RTL and testbench

Sequences all traffic to the RTC bus-cycle engine, which owns the multiplexed AD bus and the CS/RD/WR/AD strobes. Runs a periodic refresh sweep: one latch command write, then reads of the time/date registers into a shadow register file used by the display path. Arbitrates user write requests from the switch/edit logic against the sweep. Adds a per-transaction timeout with a sticky error flag.

---
 rtl/rtc_access_scheduler.sv | 221 ++++++++++++++++++++++
 tb/tb_rtc_access_scheduler.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rtc_access_scheduler.sv
// RTC bus scheduler: periodic latch+read refresh sweep into a shadow file, user writes
// arbitrated against it, per-transaction timeout with sticky error. Issue-to-done latency set by the engine.
module rtc_access_scheduler #(
    parameter int unsigned REFRESH_TICKS = 100000,
    parameter int unsigned NUM_READ      = 7,
    parameter logic [7:0]  BASE_ADDR     = 8'h21,
    parameter logic [7:0]  LATCH_ADDR    = 8'hF0,
    parameter logic [7:0]  LATCH_DATA    = 8'hF0,
    parameter int unsigned TIMEOUT       = 255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wr_req,
    input  logic [7:0] wr_addr,
    input  logic [7:0] wr_data,
    output logic       wr_ack,
    output logic       bus_start,
    output logic       bus_write,
    output logic [7:0] bus_addr,
    output logic [7:0] bus_wdata,
    input  logic [7:0] bus_rdata,
    input  logic       bus_done,
    input  logic [3:0] rd_sel,
    output logic [7:0] rd_data,
    output logic       sweep_done,
    output logic       busy,
    output logic       overrun,
    output logic       err
);

    localparam int TW = $clog2(REFRESH_TICKS);
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(REFRESH_TICKS - 1);
    localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT - 1);
    localparam logic [3:0]    LAST_IDX  = 4'(NUM_READ - 1);
    localparam logic [4:0]    NUM_RD5   = 5'(NUM_READ);

    typedef enum logic [2:0] {
        IDLE, WR_ISSUE, WR_WAIT, LT_ISSUE, LT_WAIT, RD_ISSUE, RD_WAIT
    } state_t;

    state_t        state, state_nx;
    logic [TW-1:0] tick;
    logic [CW-1:0] wait_cnt;
    logic [3:0]    idx, idx_nx;
    logic          sweep_pending;
    logic          sweep_act;
    logic [7:0]    shadow [16];
    logic          hold_write;
    logic [7:0]    hold_addr;
    logic [7:0]    hold_wdata;

    logic          wrap;
    logic          is_issue;
    logic          is_wait;
    logic          tmo;
    logic          pend_clr;
    logic          sweep_set;
    logic          sweep_clr;
    logic          shadow_we;
    logic          done_nx;
    logic          err_set;
    logic          iss_write;
    logic [7:0]    iss_addr;
    logic [7:0]    iss_wdata;

    assign wrap     = (tick == TICK_LAST);
    assign is_issue = (state == WR_ISSUE) || (state == LT_ISSUE) || (state == RD_ISSUE);
    assign is_wait  = (state == WR_WAIT) || (state == LT_WAIT) || (state == RD_WAIT);
    // bus_done in the same cycle as the limit takes precedence over the abort
    assign tmo      = is_wait && (wait_cnt == WAIT_LAST) && !bus_done;

    assign busy      = (state != IDLE);
    assign bus_start = is_issue;
    assign bus_write = is_issue ? iss_write : (is_wait ? hold_write : 1'b0);
    assign bus_addr  = is_issue ? iss_addr  : (is_wait ? hold_addr  : 8'h00);
    assign bus_wdata = is_issue ? iss_wdata : (is_wait ? hold_wdata : 8'h00);
    assign rd_data   = ({1'b0, rd_sel} < NUM_RD5) ? shadow[rd_sel] : 8'h00;

    always_comb begin
        iss_write = 1'b0;
        iss_addr  = 8'h00;
        iss_wdata = 8'h00;
        case (state)
            WR_ISSUE: begin
                iss_write = 1'b1;
                iss_addr  = wr_addr;
                iss_wdata = wr_data;
            end
            LT_ISSUE: begin
                iss_write = 1'b1;
                iss_addr  = LATCH_ADDR;
                iss_wdata = LATCH_DATA;
            end
            RD_ISSUE: iss_addr = BASE_ADDR + {4'h0, idx};
            default: ;
        endcase
    end

    always_comb begin
        state_nx  = state;
        idx_nx    = idx;
        pend_clr  = 1'b0;
        sweep_set = 1'b0;
        sweep_clr = 1'b0;
        shadow_we = 1'b0;
        done_nx   = 1'b0;
        err_set   = 1'b0;
        wr_ack    = 1'b0;
        case (state)
            IDLE: begin
                if (wr_req) begin
                    state_nx = WR_ISSUE;
                end else if (sweep_pending) begin
                    state_nx  = LT_ISSUE;
                    pend_clr  = 1'b1;
                    sweep_set = 1'b1;
                    idx_nx    = 4'd0;
                end
            end
            WR_ISSUE: state_nx = WR_WAIT;
            WR_WAIT: begin
                if (bus_done) begin
                    wr_ack   = 1'b1;
                    state_nx = sweep_act ? RD_ISSUE : IDLE;
                end else if (tmo) begin
                    wr_ack    = 1'b1;
                    err_set   = 1'b1;
                    sweep_clr = 1'b1;
                    state_nx  = IDLE;
                end
            end
            LT_ISSUE: state_nx = LT_WAIT;
            // no write may slip in between the latch and the first read
            LT_WAIT: begin
                if (bus_done) begin
                    state_nx = RD_ISSUE;
                end else if (tmo) begin
                    err_set   = 1'b1;
                    sweep_clr = 1'b1;
                    state_nx  = IDLE;
                end
            end
            RD_ISSUE: state_nx = RD_WAIT;
            RD_WAIT: begin
                if (bus_done) begin
                    shadow_we = 1'b1;
                    if (idx == LAST_IDX) begin
                        done_nx   = 1'b1;
                        sweep_clr = 1'b1;
                        state_nx  = IDLE;
                    end else begin
                        idx_nx   = idx + 4'd1;
                        state_nx = wr_req ? WR_ISSUE : RD_ISSUE;
                    end
                end else if (tmo) begin
                    err_set   = 1'b1;
                    sweep_clr = 1'b1;
                    state_nx  = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            tick          <= '0;
            wait_cnt      <= '0;
            idx           <= 4'd0;
            sweep_pending <= 1'b0;
            sweep_act     <= 1'b0;
            hold_write    <= 1'b0;
            hold_addr     <= 8'h00;
            hold_wdata    <= 8'h00;
            sweep_done    <= 1'b0;
            overrun       <= 1'b0;
            err           <= 1'b0;
            for (int i = 0; i < 16; i++) begin
                shadow[i] <= 8'h00;
            end
        end else begin
            state <= state_nx;
            idx   <= idx_nx;
            tick  <= wrap ? '0 : tick + TW'(1);
            if (wrap) begin
                sweep_pending <= 1'b1;
            end else if (pend_clr) begin
                sweep_pending <= 1'b0;
            end
            // a trigger consumed in this very cycle does not count as overrun
            if (wrap && ((sweep_pending && !pend_clr) || sweep_act)) begin
                overrun <= 1'b1;
            end
            if (sweep_set) begin
                sweep_act <= 1'b1;
            end else if (sweep_clr) begin
                sweep_act <= 1'b0;
            end
            if (is_issue) begin
                wait_cnt <= '0;
            end else if (is_wait) begin
                wait_cnt <= wait_cnt + CW'(1);
            end
            if (is_issue) begin
                hold_write <= iss_write;
                hold_addr  <= iss_addr;
                hold_wdata <= iss_wdata;
            end
            if (shadow_we) begin
                shadow[idx] <= bus_rdata;
            end
            sweep_done <= done_nx;
            if (err_set) begin
                err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_rtc_access_scheduler.sv
// Bench for rtc_access_scheduler: behavioural bus engine with a transaction scoreboard,
// table-driven shadow checks and hand-written write/timeout/overrun/reset sequences.
`timescale 1ns/1ps
module tb_rtc_access_scheduler;

    localparam int RT = 40;
    localparam int TO = 255;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       wr_req = 1'b0;
    logic [7:0] wr_addr = 8'h00;
    logic [7:0] wr_data = 8'h00;
    logic       wr_ack;
    logic       bus_start;
    logic       bus_write;
    logic [7:0] bus_addr;
    logic [7:0] bus_wdata;
    logic [7:0] bus_rdata;
    logic       bus_done;
    logic [3:0] rd_sel = 4'd0;
    logic [7:0] rd_data;
    logic       sweep_done;
    logic       busy;
    logic       overrun;
    logic       err;

    rtc_access_scheduler #(
        .REFRESH_TICKS(RT), .NUM_READ(7), .BASE_ADDR(8'h21),
        .LATCH_ADDR(8'hF0), .LATCH_DATA(8'hF0), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .reset(reset), .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_ack(wr_ack), .bus_start(bus_start), .bus_write(bus_write), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_done(bus_done), .rd_sel(rd_sel),
        .rd_data(rd_data), .sweep_done(sweep_done), .busy(busy), .overrun(overrun), .err(err)
    );

    always #20 clk = ~clk;

    typedef struct {
        logic       wr;
        logic [7:0] addr;
        logic [7:0] data;
    } txn_t;

    typedef struct {
        logic [3:0] sel;
        logic [7:0] exp;
    } vec_t;

    txn_t       sb_q[$];
    int         checks = 0;
    int         errors = 0;
    int         lat = 3;
    logic [7:0] rd_off = 8'h00;
    logic       drop_en = 1'b0;
    logic [7:0] drop_addr = 8'h00;
    logic       sb_en = 1'b1;
    int         n_done = 0;
    int         tb_tick = 0;
    logic [7:0] exp_sh [16];

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%02h, expected 0x%02h", name, act, exp);
        end
    endtask

    // bus engine: done `lat` cycles after start, rdata = 0x10 + addr[3:0] + rd_off
    initial begin
        int   cnt;
        logic [7:0] cur_addr;
        txn_t t;
        cnt = 0;
        cur_addr = 8'h00;
        bus_done = 1'b0;
        bus_rdata = 8'h00;
        forever begin
            @(posedge clk);
            #1;
            bus_done = 1'b0;
            if (reset) begin
                cnt = 0;
            end else begin
                if (cnt > 0) begin
                    cnt--;
                    if (cnt == 0) begin
                        bus_done = 1'b1;
                        bus_rdata = 8'h10 + {4'h0, cur_addr[3:0]} + rd_off;
                    end
                end
                if (bus_start) begin
                    cur_addr = bus_addr;
                    if (sb_en) begin
                        if (sb_q.size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL txn: unexpected transaction write=%0b addr=0x%02h, none expected",
                                     bus_write, bus_addr);
                        end else begin
                            t = sb_q.pop_front();
                            check8("txn_write", {7'b0, bus_write}, {7'b0, t.wr});
                            check8("txn_addr", bus_addr, t.addr);
                            if (t.wr) check8("txn_wdata", bus_wdata, t.data);
                        end
                    end
                    if (drop_en && !bus_write && bus_addr == drop_addr) drop_en = 1'b0;
                    else cnt = lat;
                end
            end
        end
    end

    initial forever begin
        @(posedge clk);
        if (reset) tb_tick = 0;
        else tb_tick = (tb_tick == RT - 1) ? 0 : tb_tick + 1;
    end

    initial forever begin
        @(posedge clk);
        #1;
        if (sweep_done) n_done++;
    end

    task automatic next_cycle();
        @(posedge clk);
        #2;
    endtask

    task automatic push_wr(input logic [7:0] a, input logic [7:0] d);
        sb_q.push_back('{wr: 1'b1, addr: a, data: d});
    endtask

    task automatic push_rd(input int i);
        sb_q.push_back('{wr: 1'b0, addr: 8'h21 + 8'(i), data: 8'h00});
    endtask

    task automatic push_sweep();
        push_wr(8'hF0, 8'hF0);
        for (int i = 0; i < 7; i++) push_rd(i);
    endtask

    task automatic wait_done(input int target, input string name);
        int n;
        n = 0;
        while (n_done < target && n < 2000) begin
            next_cycle();
            n++;
        end
        check8(name, 8'(n_done), 8'(target));
    endtask

    task automatic wait_ack(input string name);
        int n;
        n = 0;
        while (!wr_ack && n < 400) begin
            next_cycle();
            n++;
        end
        check8(name, {7'b0, wr_ack}, 8'h01);
        wr_req = 1'b0;
    endtask

    task automatic check_shadow(input string name);
        for (int i = 0; i < 16; i++) begin
            rd_sel = 4'(i);
            #1;
            check8($sformatf("%s[%0d]", name, i), rd_data, exp_sh[i]);
        end
    endtask

    task automatic set_exp(input logic [7:0] off);
        for (int i = 0; i < 16; i++) exp_sh[i] = (i < 7) ? 8'h11 + 8'(i) + off : 8'h00;
    endtask

    initial begin
        vec_t tbl [16];
        int   n;
        int   nl;
        int   nd0;

        for (int i = 0; i < 16; i++) begin
            tbl[i].sel = 4'(i);
            tbl[i].exp = (i < 7) ? 8'h11 + 8'(i) : 8'h00;
        end

        #5;
        check8("rst_busy", {7'b0, busy}, 8'h00);
        check8("rst_start", {7'b0, bus_start}, 8'h00);
        check8("rst_addr", bus_addr, 8'h00);
        check8("rst_rd_data", rd_data, 8'h00);
        check8("rst_err", {7'b0, err}, 8'h00);
        next_cycle();
        next_cycle();
        reset = 1'b0;

        // plain sweep: latch then reads 21..27
        push_sweep();
        wait_done(1, "sweep1_done");
        next_cycle();
        check8("sweep1_busy", {7'b0, busy}, 8'h00);
        for (int i = 0; i < 16; i++) begin
            rd_sel = tbl[i].sel;
            #1;
            check8($sformatf("sweep1_shadow[%0d]", i), rd_data, tbl[i].exp);
        end
        next_cycle();
        check8("sweep1_once", 8'(n_done), 8'd1);

        // write request in the trigger cycle goes first
        n = 0;
        while (tb_tick != RT - 1 && n < 100) begin
            next_cycle();
            n++;
        end
        wr_addr = 8'h22;
        wr_data = 8'h45;
        wr_req = 1'b1;
        push_wr(8'h22, 8'h45);
        push_sweep();
        wait_ack("prio_ack");
        wait_done(2, "prio_done");
        set_exp(8'h00);
        check_shadow("prio_shadow");
        check8("prio_sb_empty", 8'(sb_q.size()), 8'd0);

        // write arriving during the read of 0x22 suspends the sweep
        rd_off = 8'h40;
        push_wr(8'hF0, 8'hF0);
        push_rd(0);
        push_rd(1);
        push_wr(8'h23, 8'h12);
        for (int i = 2; i < 7; i++) push_rd(i);
        n = 0;
        while (!(bus_start && !bus_write && bus_addr == 8'h22) && n < 200) begin
            next_cycle();
            n++;
        end
        wr_addr = 8'h23;
        wr_data = 8'h12;
        wr_req = 1'b1;
        wait_ack("mid_ack");
        wait_done(3, "mid_done");
        set_exp(8'h40);
        check_shadow("mid_shadow");
        check8("mid_sb_empty", 8'(sb_q.size()), 8'd0);
        check8("mid_overrun", {7'b0, overrun}, 8'h00);
        check8("mid_err", {7'b0, err}, 8'h00);

        // slow engine: sweeps longer than the refresh period
        lat = 5;
        for (int k = 0; k < 3; k++) push_sweep();
        n = 0;
        while (n_done < 6 && n < 2000) begin
            next_cycle();
            n++;
        end
        sb_en = 1'b0;
        lat = 1;
        check8("ovr_done", 8'(n_done), 8'd6);
        check8("ovr_flag", {7'b0, overrun}, 8'h01);
        check8("ovr_sb_empty", 8'(sb_q.size()), 8'd0);
        nl = 0;
        n = 0;
        while (nl < 3 && n < 500) begin
            next_cycle();
            n++;
            if (bus_start && bus_write && bus_addr == 8'hF0) nl++;
        end
        check8("ovr_latches", 8'(nl), 8'd3);
        check8("ovr_no_backlog", 8'(tb_tick), 8'd1);
        wait_done(n_done + 1, "ovr_tail_done");
        lat = 3;
        sb_en = 1'b1;

        // timeout on the read of 0x24, then a normal sweep
        rd_off = 8'h20;
        drop_addr = 8'h24;
        drop_en = 1'b1;
        push_wr(8'hF0, 8'hF0);
        for (int i = 0; i < 4; i++) push_rd(i);
        push_sweep();
        nd0 = n_done;
        n = 0;
        while (!(bus_start && !bus_write && bus_addr == 8'h24) && n < 200) begin
            next_cycle();
            n++;
        end
        n = 0;
        while (!err && n < 800) begin
            next_cycle();
            n++;
        end
        check8("tmo_err", {7'b0, err}, 8'h01);
        check8("tmo_latency", 8'(n), 8'(TO + 1));
        check8("tmo_busy", {7'b0, busy}, 8'h00);
        check8("tmo_no_done", 8'(n_done), 8'(nd0));
        for (int i = 0; i < 16; i++)
            exp_sh[i] = (i < 3) ? 8'h31 + 8'(i) : ((i < 7) ? 8'h51 + 8'(i) : 8'h00);
        check_shadow("tmo_shadow");
        wait_done(nd0 + 1, "tmo_recover_done");
        set_exp(8'h20);
        check_shadow("tmo_recover_shadow");
        check8("tmo_sb_empty", 8'(sb_q.size()), 8'd0);
        check8("tmo_err_sticky", {7'b0, err}, 8'h01);

        // async reset while a read is outstanding
        sb_en = 1'b0;
        n = 0;
        while (!(bus_start && !bus_write) && n < 200) begin
            next_cycle();
            n++;
        end
        next_cycle();
        reset = 1'b1;
        #1;
        check8("arst_busy", {7'b0, busy}, 8'h00);
        check8("arst_start", {7'b0, bus_start}, 8'h00);
        check8("arst_write", {7'b0, bus_write}, 8'h00);
        check8("arst_addr", bus_addr, 8'h00);
        check8("arst_wdata", bus_wdata, 8'h00);
        check8("arst_ack", {7'b0, wr_ack}, 8'h00);
        check8("arst_sweep_done", {7'b0, sweep_done}, 8'h00);
        check8("arst_overrun", {7'b0, overrun}, 8'h00);
        check8("arst_err", {7'b0, err}, 8'h00);
        set_exp(8'h00);
        for (int i = 0; i < 16; i++) exp_sh[i] = 8'h00;
        check_shadow("arst_shadow");
        next_cycle();
        next_cycle();
        reset = 1'b0;
        n = 0;
        while (!bus_start && n < 200) begin
            next_cycle();
            n++;
        end
        check8("arst_first_start", 8'(n), 8'(RT + 1));
        check8("arst_first_write", {7'b0, bus_write}, 8'h01);
        check8("arst_first_addr", bus_addr, 8'hF0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
